bp_factor_node_p: RTL and testbench
===================================

BP_FACTOR_NODE_P -- requirements
Module: bp_factor_node_p

Interface
REQ-001 SHALL have parameter W, default 8: unsigned message/belief width in bits.
REQ-002 SHALL have parameter NCH, default 4: variable channel count; power of two, >= 2; LOG2NCH = log2(NCH).
REQ-003 SHALL have parameter MAXIT, default 16: iteration limit, >= 1.
REQ-004 SHALL have parameter TOL, default 0: convergence tolerance, in LSBs.
REQ-005 SHALL have port Clk  in  1  single clock; all registers update on the rising edge.
REQ-006 SHALL have port Reset  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port msg_in  in  NCH*W  incoming messages; channel i occupies bits [i*W +: W].
REQ-008 SHALL have port in_valid  in  1  msg_in is valid.
REQ-009 SHALL have port in_ready  out  1  block can accept a message set.
REQ-010 SHALL have port belief_out  out  NCH*W  final beliefs, packed the same way as msg_in.
REQ-011 SHALL have port iter_count  out  clog2(MAXIT+1)  number of iterations executed.
REQ-012 SHALL have port converged  out  1  high if the run stopped on tolerance, low if it stopped on MAXIT.
REQ-013 SHALL have port out_valid  in/out pair: out_valid  out  1  results valid.
REQ-014 SHALL have port out_ready  in  1  consumer accepts the results.
REQ-015 SHALL have port busy  out  1  high while in state ITER.

Function
REQ-016 SHALL implement a three-state FSM: IDLE -> ITER on in_valid&&in_ready; ITER -> DONE on stop; DONE -> IDLE on out_valid&&out_ready.
REQ-017 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE; in_valid outside IDLE is ignored.
REQ-018 SHALL, on the accept edge, latch msg_in into in_reg[i], load belief b[i]=in_reg[i] and clear iter_count.
REQ-019 SHALL perform exactly one iteration per ITER cycle: S = sum of b[j] at W+LOG2NCH bits (never overflows); t[i] = (S - b[i]) >> LOG2NCH; n[i] = min(in_reg[i] + t[i], 2^W-1).
REQ-020 SHALL update b[i] from n[i] and b[i] per REQ-029/REQ-030, and SHALL increment iter_count in the same cycle.
REQ-021 SHALL stop when max over i of |b_new[i] - b_old[i]| <= TOL (converged=1), or when the updated iter_count equals MAXIT (converged = the tolerance test result).
REQ-022 SHALL, on the stop edge, register the final b, iter_count and converged, and enter DONE; out_valid is first high in the cycle after the final iteration.
REQ-023 SHALL hold belief_out, iter_count and converged stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when out_ready=1 on DONE entry, complete the handshake in that cycle; next accept is possible one cycle later in IDLE.

Reset
REQ-025 SHALL, while Reset=0, force state IDLE, in_ready=1, out_valid=0, busy=0, converged=0, iter_count=0, and belief_out and all internal registers to 0, regardless of Clk.
REQ-026 SHALL abort any run on reset mid-ITER or mid-DONE with no residual output; the block resumes from IDLE on the first edge after Reset returns to 1.

Configuration
REQ-027 SHALL use macro BP_DAMPING_EN to select the belief update rule.
REQ-028 SHALL produce identical interface, FSM and timing in both builds.
REQ-029 SHALL, with BP_DAMPING_EN defined, set b_new[i] = (b_old[i] + n[i] + 1) >> 1, computed at W+1 bits.
REQ-030 SHALL, without BP_DAMPING_EN, set b_new[i] = n[i].

Verification (defaults, BP_DAMPING_EN undefined, unless stated)
REQ-031 SHALL check: all channels 1 -> iter_count=1, converged=1, all beliefs 1, out_valid 2 cycles after the accept edge.
REQ-032 SHALL check: msg_in {8,0,0,0} -> beliefs per iteration {8,2,2,2},{9,3,3,3},{10,3,3,3},{10,4,4,4},{11,4,4,4},{11,4,4,4}; final iter_count=6, converged=1, result {11,4,4,4}.
REQ-033 SHALL check: all channels 255 -> t=191, result saturated to 255 on every channel, iter_count=1, converged=1.
REQ-034 SHALL check: MAXIT=3 with msg_in {8,0,0,0} -> iter_count=3, converged=0, result {10,3,3,3}.
REQ-035 SHALL check: out_ready held 0 for 5 cycles -> outputs stable and in_ready=0 throughout; pulsing in_valid during that time is ignored.
REQ-036 SHALL check: Reset driven low during the 2nd iteration, asynchronously -> immediate IDLE with in_ready=1, out_valid=0, iter_count=0, belief_out=0; a new run then completes correctly.

Source files
------------

// File: rtl/bp_factor_node_p.sv
// Belief-propagation factor node: iterates NCH beliefs against a latched message set
// until the largest change is within TOL or MAXIT iterations. Define BP_DAMPING_EN for the damped update.
module bp_factor_node_p #(
    parameter int W     = 8,
    parameter int NCH   = 4,
    parameter int MAXIT = 16,
    parameter int TOL   = 0,
    localparam int LOG2NCH = $clog2(NCH),
    localparam int IW      = $clog2(MAXIT + 1),
    localparam int SW      = W + LOG2NCH
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NCH*W-1:0]   msg_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NCH*W-1:0]   belief_out,
    output logic [IW-1:0]      iter_count,
    output logic               converged,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t state, state_nxt;

    logic [W-1:0]  msg_ch  [NCH];
    logic [W-1:0]  in_reg  [NCH];
    logic [W-1:0]  b_q     [NCH];
    logic [W-1:0]  bel_q   [NCH];
    logic [W-1:0]  t_val   [NCH];
    logic [W-1:0]  n_val   [NCH];
    logic [W-1:0]  b_new   [NCH];
    logic [W-1:0]  delta   [NCH];
    logic [SW-1:0] sum_s;
    logic [SW-1:0] rest_s;
    logic [W-1:0]  max_diff;
    logic [IW-1:0] iter_q;
    logic [IW-1:0] iter_inc;
    logic          conv_q;
    logic          tol_ok;
    logic          stop;

    function automatic logic [W-1:0] sat_w(input logic [W:0] x);
        return x[W] ? {W{1'b1}} : x[W-1:0];
    endfunction

`ifdef BP_DAMPING_EN
    // Rounded midpoint; the extra bit keeps the carry of a+c+1.
    function automatic logic [W-1:0] avg_round(input logic [W-1:0] a, input logic [W-1:0] c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, c} + (W+1)'(1);
        return W'(s >> 1);
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            msg_ch[i] = msg_in[i*W +: W];
        end
    end

    // Iteration datapath: full-width sum, leave-one-out share, saturating update.
    always_comb begin
        sum_s    = '0;
        rest_s   = '0;
        max_diff = '0;
        for (int i = 0; i < NCH; i++) begin
            sum_s = sum_s + SW'(b_q[i]);
        end
        for (int i = 0; i < NCH; i++) begin
            rest_s   = sum_s - SW'(b_q[i]);
            t_val[i] = W'(rest_s >> LOG2NCH);
            n_val[i] = sat_w({1'b0, in_reg[i]} + {1'b0, t_val[i]});
`ifdef BP_DAMPING_EN
            b_new[i] = avg_round(b_q[i], n_val[i]);
`else
            b_new[i] = n_val[i];
`endif
            delta[i] = (b_new[i] >= b_q[i]) ? (b_new[i] - b_q[i]) : (b_q[i] - b_new[i]);
            if (delta[i] > max_diff) begin
                max_diff = delta[i];
            end
        end
    end

    assign tol_ok   = (32'(max_diff) <= 32'(TOL));
    assign iter_inc = iter_q + IW'(1);
    assign stop     = tol_ok || (iter_inc == IW'(MAXIT));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (stop) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NCH; i++) begin
                in_reg[i] <= '0;
                b_q[i]    <= '0;
                bel_q[i]  <= '0;
            end
            iter_q <= '0;
            conv_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NCH; i++) begin
                            in_reg[i] <= msg_ch[i];
                            b_q[i]    <= msg_ch[i];
                        end
                        iter_q <= '0;
                        conv_q <= 1'b0;
                    end
                end
                ITER: begin
                    for (int i = 0; i < NCH; i++) begin
                        b_q[i] <= b_new[i];
                    end
                    iter_q <= iter_inc;
                    if (stop) begin
                        for (int i = 0; i < NCH; i++) begin
                            bel_q[i] <= b_new[i];
                        end
                        conv_q <= tol_ok;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        belief_out = '0;
        for (int i = 0; i < NCH; i++) begin
            belief_out[i*W +: W] = bel_q[i];
        end
    end

    assign iter_count = iter_q;
    assign converged  = conv_q;

endmodule

// File: tb/tb_bp_factor_node_p.sv
// Directed bench for bp_factor_node_p: vector table plus reset, MAXIT, backpressure and abort sequences.
module tb_bp_factor_node_p;

    localparam int W   = 8;
    localparam int NCH = 4;
    localparam int IW  = $clog2(16 + 1);
    localparam int IW3 = $clog2(3 + 1);

    logic             Clk_tb = 1'b0;
    logic             Reset_tb;
    logic [NCH*W-1:0] msg_in;
    logic             in_valid;
    logic             in_ready;
    logic [NCH*W-1:0] belief_out;
    logic [IW-1:0]    iter_count;
    logic             converged;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    logic [NCH*W-1:0] msg_in3;
    logic             in_valid3;
    logic             in_ready3;
    logic [NCH*W-1:0] belief_out3;
    logic [IW3-1:0]   iter_count3;
    logic             converged3;
    logic             out_valid3;
    logic             out_ready3;
    logic             busy3;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 Clk_tb = ~Clk_tb;

    bp_factor_node_p #(.W(W), .NCH(NCH), .MAXIT(16), .TOL(0)) dut (
        .Clk(Clk_tb), .Reset(Reset_tb), .msg_in(msg_in), .in_valid(in_valid),
        .in_ready(in_ready), .belief_out(belief_out), .iter_count(iter_count),
        .converged(converged), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    bp_factor_node_p #(.W(W), .NCH(NCH), .MAXIT(3), .TOL(0)) dut3 (
        .Clk(Clk_tb), .Reset(Reset_tb), .msg_in(msg_in3), .in_valid(in_valid3),
        .in_ready(in_ready3), .belief_out(belief_out3), .iter_count(iter_count3),
        .converged(converged3), .out_valid(out_valid3), .out_ready(out_ready3), .busy(busy3)
    );

    typedef struct {
        logic [NCH*W-1:0] msg;
        logic [NCH*W-1:0] bel;
        int               iters;
        logic             conv;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [NCH*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        int lat;
        @(negedge Clk_tb);
        chk($sformatf("v%0d in_ready idle", idx), 64'(in_ready), 64'(1));
        msg_in    = vecs[idx].msg;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge Clk_tb);
        in_valid = 1'b0;
        msg_in   = '0;
        chk($sformatf("v%0d busy after accept", idx), 64'(busy), 64'(1));
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge Clk_tb);
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(vecs[idx].iters));
        chk($sformatf("v%0d belief", idx), 64'(belief_out), 64'(vecs[idx].bel));
        chk($sformatf("v%0d iter_count", idx), 64'(iter_count), 64'(vecs[idx].iters));
        chk($sformatf("v%0d converged", idx), 64'(converged), 64'(vecs[idx].conv));
        @(negedge Clk_tb);
        chk($sformatf("v%0d out_valid dropped", idx), 64'(out_valid), 64'(0));
        chk($sformatf("v%0d back to idle", idx), 64'(in_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{pack4(1, 1, 1, 1),       pack4(1, 1, 1, 1),       1,  1'b1};
        vecs[1] = '{pack4(8, 0, 0, 0),       pack4(11, 4, 4, 4),      6,  1'b1};
        vecs[2] = '{pack4(255, 255, 255, 255), pack4(255, 255, 255, 255), 1, 1'b1};
        vecs[3] = '{pack4(0, 0, 0, 0),       pack4(0, 0, 0, 0),       1,  1'b1};
        vecs[4] = '{pack4(4, 4, 4, 4),       pack4(13, 13, 13, 13),   7,  1'b1};
        vecs[5] = '{pack4(0, 0, 0, 100),     pack4(77, 77, 77, 157),  14, 1'b1};

        msg_in = '0;  in_valid = 1'b0;  out_ready = 1'b1;
        msg_in3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;

        // Reset state, applied asynchronously
        Reset_tb = 1'b1;
        #1 Reset_tb = 1'b0;
        #2;
        chk("rst in_ready", 64'(in_ready), 64'(1));
        chk("rst out_valid", 64'(out_valid), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst converged", 64'(converged), 64'(0));
        chk("rst iter_count", 64'(iter_count), 64'(0));
        chk("rst belief_out", 64'(belief_out), 64'(0));
        repeat (2) @(negedge Clk_tb);
        Reset_tb = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(i);
        end

        // Iteration limit reached before convergence
        @(negedge Clk_tb);
        msg_in3 = pack4(8, 0, 0, 0);
        in_valid3 = 1'b1;
        @(negedge Clk_tb);
        in_valid3 = 1'b0;
        lat = 0;
        while (!out_valid3 && lat < 200) begin
            @(negedge Clk_tb);
            lat++;
        end
        chk("maxit latency", 64'(lat), 64'(3));
        chk("maxit belief", 64'(belief_out3), 64'(pack4(10, 3, 3, 3)));
        chk("maxit iter_count", 64'(iter_count3), 64'(3));
        chk("maxit converged", 64'(converged3), 64'(0));
        @(negedge Clk_tb);
        chk("maxit idle", 64'(in_ready3), 64'(1));

        // Backpressure: results held, in_valid ignored
        @(negedge Clk_tb);
        msg_in = pack4(8, 0, 0, 0);
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge Clk_tb);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge Clk_tb);
            lat++;
        end
        chk("bp latency", 64'(lat), 64'(6));
        msg_in = pack4(1, 1, 1, 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            @(negedge Clk_tb);
            chk($sformatf("bp hold belief c%0d", k), 64'(belief_out), 64'(pack4(11, 4, 4, 4)));
            chk($sformatf("bp hold iter c%0d", k), 64'(iter_count), 64'(6));
            chk($sformatf("bp hold conv c%0d", k), 64'(converged), 64'(1));
            chk($sformatf("bp out_valid c%0d", k), 64'(out_valid), 64'(1));
            chk($sformatf("bp in_ready c%0d", k), 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk_tb);
        chk("bp release out_valid", 64'(out_valid), 64'(0));
        chk("bp release in_ready", 64'(in_ready), 64'(1));
        chk("bp no stray run", 64'(busy), 64'(0));
        chk("bp belief kept", 64'(belief_out), 64'(pack4(11, 4, 4, 4)));

        // Abort during the second iteration
        @(negedge Clk_tb);
        msg_in = pack4(8, 0, 0, 0);
        in_valid = 1'b1;
        @(negedge Clk_tb);
        in_valid = 1'b0;
        chk("abort iter0", 64'(iter_count), 64'(0));
        @(negedge Clk_tb);
        chk("abort iter1", 64'(iter_count), 64'(1));
        chk("abort busy", 64'(busy), 64'(1));
        #2 Reset_tb = 1'b0;
        #1;
        chk("abort in_ready", 64'(in_ready), 64'(1));
        chk("abort out_valid", 64'(out_valid), 64'(0));
        chk("abort busy low", 64'(busy), 64'(0));
        chk("abort iter_count", 64'(iter_count), 64'(0));
        chk("abort belief_out", 64'(belief_out), 64'(0));
        chk("abort converged", 64'(converged), 64'(0));
        @(negedge Clk_tb);
        Reset_tb = 1'b1;
        run_vec(1);
        run_vec(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
